// File: rtl/spike_weight_accumulator_pkg.sv
// Shared constants, packet field positions, config selects, FSM states and
// arithmetic helpers for the spike weight accumulator.
package snn_pkg;

    localparam int NEURON_ADDR_W = 10;
    localparam int NUM_NEURONS   = 10;
    localparam int MAX_CONN      = 30;
    localparam int WEIGHT_W      = 16;
    localparam int ACC_W         = 20;

    // Pointer width covers indices 0..MAX_CONN (row_ptr may equal MAX_CONN)
    localparam int PTR_W = 5;
    // Row index width covers 0..NUM_NEURONS for the row_ptr table
    localparam int ROW_W = 4;

    localparam int DEST_MSB = 2*NEURON_ADDR_W - 1;
    localparam int DEST_LSB = NEURON_ADDR_W;
    localparam int SRC_MSB  = NEURON_ADDR_W - 1;
    localparam int SRC_LSB  = 0;

    typedef enum logic [1:0] {
        CFG_ROWPTR = 2'd0,
        CFG_SRC    = 2'd1,
        CFG_WEIGHT = 2'd2
    } cfg_sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        ACCUM  = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Signed add of a weight into an accumulator, clamped to the accumulator range
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0]    acc,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [ACC_W:0] sum;
        sum = (ACC_W+1)'(acc) + (ACC_W+1)'(w);
        if (sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return sum[ACC_W-1:0];
    endfunction

    // Eight-bit counter increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spike_weight_accumulator_if.sv
// Spike, configuration and drain-stream signals of the accumulator.
// master = the upstream/config driver, slave = the accumulator itself.
interface spike_weight_accumulator_if;
    import snn_pkg::*;

    logic                          spike_valid;
    logic [2*NEURON_ADDR_W-1:0]    spike_packet;
    logic                          spike_ready;
    logic                          timestep_end;
    logic                          cfg_we;
    logic [1:0]                    cfg_sel;
    logic [4:0]                    cfg_addr;
    logic [15:0]                   cfg_wdata;
    logic                          acc_valid;
    logic [NEURON_ADDR_W-1:0]      acc_neuron;
    logic signed [ACC_W-1:0]       acc_value;
    logic [7:0]                    drop_count;
    logic                          busy;

    modport master (
        output spike_valid, spike_packet, timestep_end,
        output cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        input  spike_ready, acc_valid, acc_neuron, acc_value, drop_count, busy
    );

    modport slave (
        input  spike_valid, spike_packet, timestep_end,
        input  cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        output spike_ready, acc_valid, acc_neuron, acc_value, drop_count, busy
    );

endinterface

// File: rtl/spike_csr_lookup.sv
// CSR connection lookup: owns row_ptr and src_addr tables and walks one
// entry of the destination's row per cycle looking for the source neuron.
module spike_csr_lookup
    import snn_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     rp_we,
    input  logic                     sa_we,
    input  logic [PTR_W-1:0]         cfg_addr,
    input  logic [PTR_W-1:0]         rp_wdata,
    input  logic [NEURON_ADDR_W-1:0] sa_wdata,
    input  logic                     start,
    input  logic [ROW_W-1:0]         dest,
    input  logic [NEURON_ADDR_W-1:0] src,
    output logic                     done,
    output logic                     hit,
    output logic [PTR_W-1:0]         index
);

    logic [PTR_W-1:0]         row_ptr  [NUM_NEURONS+1];
    logic [NEURON_ADDR_W-1:0] src_addr [MAX_CONN];

    logic                     active;
    logic [PTR_W-1:0]         ptr;
    logic [ROW_W-1:0]         dest_q;
    logic [NEURON_ADDR_W-1:0] src_q;
    logic [PTR_W-1:0]         row_end;
    logic                     at_end;
    logic                     match;

    // Configuration tables survive reset so a reset does not wipe the network
    always_ff @(posedge CLK) begin
        if (rp_we && (cfg_addr < PTR_W'(NUM_NEURONS + 1)))
            row_ptr[cfg_addr[ROW_W-1:0]] <= rp_wdata;
        if (sa_we && (cfg_addr < PTR_W'(MAX_CONN)))
            src_addr[cfg_addr] <= sa_wdata;
    end

    // Pointer walk: load the row start on start, then advance until done
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            active <= 1'b0;
            ptr    <= '0;
            dest_q <= '0;
            src_q  <= '0;
        end else if (start) begin
            active <= 1'b1;
            dest_q <= dest;
            src_q  <= src;
            ptr    <= row_ptr[dest];
        end else if (active) begin
            if (done)
                active <= 1'b0;
            else
                ptr <= ptr + 1'b1;
        end
    end

    // End-of-row has priority so an empty row never reads past its slice;
    // running off the table end is treated as end-of-row as well
    always_comb begin
        row_end = row_ptr[dest_q + ROW_W'(1)];
        at_end  = (ptr == row_end) || (ptr >= PTR_W'(MAX_CONN));
        match   = !at_end && (src_addr[ptr] == src_q);
        done    = active && (at_end || match);
        hit     = active && match;
        index   = ptr;
    end

endmodule

// File: rtl/spike_weight_accumulator.sv
// Spike weight accumulator: looks up each spike's synapse weight, adds it
// into the destination's current accumulator and drains all accumulators
// to the neuron units at each timestep boundary.
module spike_weight_accumulator
    import snn_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RESET,
    spike_weight_accumulator_if.slave  bus
);

    state_e                     state;
    logic                       ts_pending;
    logic [ROW_W-1:0]           dest_q;
    logic [ROW_W-1:0]           drain_idx;
    logic signed [WEIGHT_W-1:0] weight [MAX_CONN];
    logic signed [WEIGHT_W-1:0] weight_q;
    logic signed [ACC_W-1:0]    acc [NUM_NEURONS];
    logic                       acc_valid_q;
    logic [NEURON_ADDR_W-1:0]   acc_neuron_q;
    logic signed [ACC_W-1:0]    acc_value_q;
    logic [7:0]                 drop_count_q;

    logic [NEURON_ADDR_W-1:0]   pkt_dest;
    logic [NEURON_ADDR_W-1:0]   pkt_src;
    logic                       transfer;
    logic                       dest_ok;
    logic                       cfg_ok;
    logic                       lk_done;
    logic                       lk_hit;
    logic [PTR_W-1:0]           lk_index;

    assign pkt_dest = bus.spike_packet[DEST_MSB:DEST_LSB];
    assign pkt_src  = bus.spike_packet[SRC_MSB:SRC_LSB];
    assign dest_ok  = pkt_dest < NEURON_ADDR_W'(NUM_NEURONS);
    assign cfg_ok   = bus.cfg_we && (state == IDLE);

    assign bus.spike_ready = (state == IDLE) && !bus.timestep_end && !ts_pending;
    assign transfer        = bus.spike_valid && bus.spike_ready;
    assign bus.busy        = (state != IDLE);
    assign bus.acc_valid   = acc_valid_q;
    assign bus.acc_neuron  = acc_neuron_q;
    assign bus.acc_value   = acc_value_q;
    assign bus.drop_count  = drop_count_q;

    spike_csr_lookup u_lookup (
        .CLK      (CLK),
        .RESET    (RESET),
        .rp_we    (cfg_ok && (bus.cfg_sel == CFG_ROWPTR)),
        .sa_we    (cfg_ok && (bus.cfg_sel == CFG_SRC)),
        .cfg_addr (bus.cfg_addr),
        .rp_wdata (bus.cfg_wdata[PTR_W-1:0]),
        .sa_wdata (bus.cfg_wdata[NEURON_ADDR_W-1:0]),
        .start    (transfer && dest_ok),
        .dest     (pkt_dest[ROW_W-1:0]),
        .src      (pkt_src),
        .done     (lk_done),
        .hit      (lk_hit),
        .index    (lk_index)
    );

    // Weight table write port, kept out of reset like the other CSR tables
    always_ff @(posedge CLK) begin
        if (cfg_ok && (bus.cfg_sel == CFG_WEIGHT) && (bus.cfg_addr < PTR_W'(MAX_CONN)))
            weight[bus.cfg_addr] <= bus.cfg_wdata;
    end

    // Main sequencer: accept, search, accumulate and drain with registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            ts_pending   <= 1'b0;
            dest_q       <= '0;
            drain_idx    <= '0;
            weight_q     <= '0;
            drop_count_q <= '0;
            acc_valid_q  <= 1'b0;
            acc_neuron_q <= '0;
            acc_value_q  <= '0;
            for (int i = 0; i < NUM_NEURONS; i++)
                acc[i] <= '0;
        end else begin
            acc_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.timestep_end) begin
                        state     <= DRAIN;
                        drain_idx <= '0;
                    end else if (transfer) begin
                        if (dest_ok) begin
                            dest_q <= pkt_dest[ROW_W-1:0];
                            state  <= SEARCH;
                        end else begin
                            drop_count_q <= sat_inc8(drop_count_q);
                        end
                    end
                end
                SEARCH: begin
                    if (bus.timestep_end)
                        ts_pending <= 1'b1;
                    if (lk_done) begin
                        if (lk_hit) begin
                            weight_q <= weight[lk_index];
                            state    <= ACCUM;
                        end else begin
                            drop_count_q <= sat_inc8(drop_count_q);
                            drain_idx    <= '0;
                            state        <= (ts_pending || bus.timestep_end) ? DRAIN : IDLE;
                        end
                    end
                end
                ACCUM: begin
                    acc[dest_q] <= sat_add(acc[dest_q], weight_q);
                    drain_idx   <= '0;
                    if (ts_pending || bus.timestep_end) begin
                        ts_pending <= 1'b1;
                        state      <= DRAIN;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    acc_valid_q    <= 1'b1;
                    acc_neuron_q   <= NEURON_ADDR_W'(drain_idx);
                    acc_value_q    <= acc[drain_idx];
                    acc[drain_idx] <= '0;
                    if (drain_idx == ROW_W'(NUM_NEURONS - 1)) begin
                        state      <= IDLE;
                        ts_pending <= 1'b0;
                        drain_idx  <= '0;
                    end else begin
                        drain_idx <= drain_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_weight_accumulator.sv
// Scoreboard bench for the spike weight accumulator: stimulus pushes the
// hand-computed drain beats into a queue, a negedge monitor pops and compares.
module tb_spike_weight_accumulator;

    logic CLK;
    logic RESET;

    spike_weight_accumulator_if bus ();

    spike_weight_accumulator dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        int neuron;
        int value;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_beat;
    int    check_count = 0;
    int    pass_count  = 0;

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Pops one expected beat whenever the DUT presents a drain beat
    always @(negedge CLK) begin
        if (!RESET && bus.acc_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", int'(bus.acc_neuron), -1);
            end else begin
                mon_beat = exp_q.pop_front();
                checkOutput("drain_neuron", int'(bus.acc_neuron), mon_beat.neuron);
                checkOutput($sformatf("drain_value_n%0d", mon_beat.neuron),
                            int'(bus.acc_value), mon_beat.value);
            end
        end
    end

    task automatic applyStimulus(input int dest, input int src);
        bit accepted;
        accepted = 1'b0;
        bus.spike_packet = {10'(dest), 10'(src)};
        bus.spike_valid  = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge CLK);
            if (bus.spike_ready)
                accepted = 1'b1;
        end
        checkOutput($sformatf("spike_accept_%0d_%0d", dest, src), int'(accepted), 1);
        @(posedge CLK);
        #1;
        bus.spike_valid = 1'b0;
    endtask

    task automatic cfg_write(input int sel, input int addr, input int data);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 2'(sel);
        bus.cfg_addr  = 5'(addr);
        bus.cfg_wdata = 16'(data);
        @(posedge CLK);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_timestep();
        bus.timestep_end = 1'b1;
        @(posedge CLK);
        #1;
        bus.timestep_end = 1'b0;
    endtask

    task automatic push_drain(input int neuron, input int value);
        for (int i = 0; i < 10; i++)
            exp_q.push_back('{neuron: i, value: (i == neuron) ? value : 0});
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge CLK);
            if (!bus.busy)
                idle = 1'b1;
        end
        checkOutput("wait_idle", int'(idle), 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain();
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < 100 && !finished; i++) begin
            @(negedge CLK);
            #1;
            if (exp_q.size() == 0 && !bus.busy)
                finished = 1'b1;
        end
        checkOutput("drain_complete_pending", exp_q.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    // Directed scenario sequence
    initial begin
        int  busy_cycles;
        int  waits;
        bit  done_flag;

        RESET            = 1'b1;
        bus.spike_valid  = 1'b0;
        bus.spike_packet = '0;
        bus.timestep_end = 1'b0;
        bus.cfg_we       = 1'b0;
        bus.cfg_sel      = '0;
        bus.cfg_addr     = '0;
        bus.cfg_wdata    = '0;

        #2;
        checkOutput("reset_acc_valid", int'(bus.acc_valid), 0);
        checkOutput("reset_acc_value", int'(bus.acc_value), 0);
        checkOutput("reset_drop_count", int'(bus.drop_count), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_spike_ready", int'(bus.spike_ready), 1);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Network setup: rows 0..3 empty at 4, row 4 = [4,6), rows 5..9 empty at 6
        for (int i = 0; i <= 4; i++)
            cfg_write(0, i, 4);
        for (int i = 5; i <= 10; i++)
            cfg_write(0, i, 6);
        cfg_write(1, 4, 1);
        cfg_write(1, 5, 2);
        cfg_write(2, 4, 100);
        cfg_write(2, 5, 16'hFFE2);

        // Match at row offset 1: two SEARCH cycles plus ACCUM
        applyStimulus(4, 2);
        busy_cycles = 0;
        done_flag   = 1'b0;
        for (int i = 0; i < 20 && !done_flag; i++) begin
            @(negedge CLK);
            if (bus.busy)
                busy_cycles++;
            else
                done_flag = 1'b1;
        end
        checkOutput("search_accum_cycles", busy_cycles, 3);
        checkOutput("no_drop_on_hit", int'(bus.drop_count), 0);
        @(posedge CLK);
        #1;
        push_drain(4, -30);
        pulse_timestep();
        done_flag = 1'b0;
        for (int i = 0; i < 30 && !done_flag; i++) begin
            @(negedge CLK);
            if (bus.acc_valid && bus.acc_neuron == 10'd9)
                done_flag = 1'b1;
        end
        checkOutput("saw_beat9", int'(done_flag), 1);
        checkOutput("busy_after_beat9", int'(bus.busy), 0);
        wait_drain();

        // Saturation: 20 x 32767 exceeds the 20-bit positive limit
        cfg_write(2, 4, 16'h7FFF);
        for (int i = 0; i < 20; i++)
            applyStimulus(4, 1);
        wait_idle();
        push_drain(4, 524287);
        pulse_timestep();
        wait_drain();
        push_drain(-1, 0);
        pulse_timestep();
        wait_drain();
        cfg_write(2, 4, 100);

        // Drops: source not in the row, then destination out of range
        applyStimulus(4, 7);
        wait_idle();
        checkOutput("drop_after_miss", int'(bus.drop_count), 1);
        checkOutput("ready_after_miss", int'(bus.spike_ready), 1);
        applyStimulus(12, 0);
        checkOutput("drop_after_range", int'(bus.drop_count), 2);
        checkOutput("busy_after_range", int'(bus.busy), 0);
        checkOutput("ready_after_range", int'(bus.spike_ready), 1);
        push_drain(-1, 0);
        pulse_timestep();
        wait_drain();

        // Timestep end during SEARCH: drain follows ACCUM and includes the spike
        applyStimulus(4, 1);
        bus.timestep_end = 1'b1;
        @(posedge CLK);
        #1;
        bus.timestep_end = 1'b0;
        checkOutput("ready_low_pending", int'(bus.spike_ready), 0);
        push_drain(4, 100);
        @(posedge CLK);
        #1;
        checkOutput("ready_low_in_drain", int'(bus.spike_ready), 0);
        @(posedge CLK);
        #1;
        checkOutput("drain_starts_after_accum", int'(bus.acc_valid), 1);
        wait_drain();

        // Timestep end and spike in the same IDLE cycle: spike waits for the drain
        bus.spike_packet = {10'd4, 10'd2};
        bus.spike_valid  = 1'b1;
        bus.timestep_end = 1'b1;
        #1;
        checkOutput("ready_low_with_ts", int'(bus.spike_ready), 0);
        @(posedge CLK);
        #1;
        bus.timestep_end = 1'b0;
        push_drain(-1, 0);
        waits     = 0;
        done_flag = 1'b0;
        for (int i = 0; i < 50 && !done_flag; i++) begin
            @(negedge CLK);
            if (bus.spike_ready)
                done_flag = 1'b1;
            else
                waits++;
        end
        checkOutput("deferred_accept_seen", int'(done_flag), 1);
        checkOutput("deferred_wait_cycles", waits, 10);
        @(posedge CLK);
        #1;
        bus.spike_valid = 1'b0;
        wait_idle();
        push_drain(4, -30);
        pulse_timestep();
        wait_drain();

        // Reset during drain beat 3 aborts the drain and clears the accumulators
        applyStimulus(4, 1);
        wait_idle();
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{neuron: i, value: 0});
        pulse_timestep();
        done_flag = 1'b0;
        for (int i = 0; i < 30 && !done_flag; i++) begin
            @(negedge CLK);
            if (bus.acc_valid && bus.acc_neuron == 10'd3)
                done_flag = 1'b1;
        end
        checkOutput("saw_beat3", int'(done_flag), 1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("acc_valid_async_reset", int'(bus.acc_valid), 0);
        checkOutput("busy_async_reset", int'(bus.busy), 0);
        checkOutput("drop_async_reset", int'(bus.drop_count), 0);
        checkOutput("beats_left_after_abort", exp_q.size(), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        push_drain(-1, 0);
        pulse_timestep();
        wait_drain();
        applyStimulus(4, 2);
        wait_idle();
        push_drain(4, -30);
        pulse_timestep();
        wait_drain();

        checkOutput("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/spike_weight_accumulator.md
Name: spike_weight_accumulator

Overview:
- Sits directly downstream of the spike input cache and consumes spike packets of the form [destination neuron, source neuron].
- For each packet it walks the destination's compressed-sparse-row (CSR) upstream-connection list to find the source and fetch that synapse's weight.
- It adds the weight into a per-neuron input-current accumulator.
- On each timestep boundary it streams the accumulated currents to the neuron units, one neuron per cycle, and clears each accumulator as it goes.

Parameters:
NEURON_ADDR_W, 10, width of each neuron address field in a spike packet
NUM_NEURONS, 10, number of local destination neurons
MAX_CONN, 30, depth of the source-address and weight arrays
WEIGHT_W, 16, signed synaptic weight width
ACC_W, 20, signed accumulator width

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-high reset
spike_valid  in  1  spike_packet is valid
spike_packet  in  2*NEURON_ADDR_W  bits [19:10] = destination neuron, bits [9:0] = source neuron
spike_ready  out  1  block accepts a packet this cycle
timestep_end  in  1  single-cycle pulse marking the end of a timestep
cfg_we  in  1  configuration write strobe
cfg_sel  in  2  target array: 0 = row pointer, 1 = source address, 2 = weight, 3 = ignored
cfg_addr  in  5  array index
cfg_wdata  in  16  write data (low bits used for pointers and addresses)
acc_valid  out  1  acc_neuron and acc_value are valid
acc_neuron  out  NEURON_ADDR_W  neuron index during drain
acc_value  out  ACC_W  accumulated current, signed
drop_count  out  8  count of spikes dropped, saturates at 255
busy  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; all accumulators, acc_valid, acc_neuron, acc_value and drop_count clear to 0.
  - Configuration arrays are NOT reset.
- CSR layout:
  - row_ptr has NUM_NEURONS+1 entries; the final entry is the total connection count.
  - Connections for neuron d occupy indices row_ptr[d] .. row_ptr[d+1]-1.
  - Configuration writes complete in one cycle and are legal only while IDLE; writes in any other state are ignored.
- spike_ready = (state == IDLE) && !timestep_end && !ts_pending. A transfer occurs when spike_valid && spike_ready on a rising edge.
- FSM states: IDLE, SEARCH, ACCUM, DRAIN.
  - IDLE, on transfer: latch dest and src and load ptr = row_ptr[dest].
    - If dest >= NUM_NEURONS: increment drop_count and stay in IDLE.
    - Otherwise go to SEARCH.
  - SEARCH examines one entry per cycle.
    - If ptr == row_ptr[dest+1] (end of row, including an empty row): increment drop_count and go to IDLE.
    - If src_addr[ptr] == src: latch weight[ptr] and go to ACCUM.
    - Otherwise ptr++.
    - The first matching index wins.
  - ACCUM, one cycle: acc[dest] = acc[dest] + sign-extended weight, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Then go to DRAIN if ts_pending, else IDLE.
  - Latency from accept to accumulator update is 1 + (k+1) + 1 cycles for a match at row offset k.
  - DRAIN covers NUM_NEURONS consecutive cycles. Cycle i drives acc_valid=1, acc_neuron=i, acc_value=acc[i], and clears acc[i] to 0. After the last neuron the FSM returns to IDLE and clears ts_pending.
- timestep_end handling:
  - In IDLE: enter DRAIN next cycle. A simultaneous spike_valid is not accepted (spike_ready is 0).
  - In SEARCH or ACCUM: set ts_pending. The in-flight spike completes and is included in the drain.
  - In DRAIN: ignored.
- acc_valid is registered and is 0 outside DRAIN.
- drop_count holds at 255.
- RESET asserted mid-SEARCH or mid-DRAIN aborts the operation immediately: acc_valid falls asynchronously and no partial drain resumes.

Decomposition:
- Package snn_pkg:
  - NEURON_ADDR_W
  - packet field positions (DEST_MSB/LSB, SRC_MSB/LSB)
  - cfg_sel encodings (CFG_ROWPTR, CFG_SRC, CFG_WEIGHT)
  - FSM state enum
  - saturating-add function
- Sub-module spike_csr_lookup:
  - holds row_ptr and src_addr arrays plus the pointer walk
  - start/dest/src in; done/hit/index out
  - top level owns the weights, accumulators, drain sequencing and drop counter

Test Plan:
- Setup for all scenarios:
  - row_ptr: [4]=4, [5]=6
  - src_addr: [4]=1, [5]=2
  - weight: [4]=100, [5]=-30
- Packet {dest 4, src 2}, then timestep_end → match after 2 SEARCH cycles. Drain emits 10 beats; neuron 4 shows -30, all others 0; busy drops after beat 9.
- weight[4]=0x7FFF; 20 packets {4,1}, then timestep_end → acc[4] saturates at 524287 with no wrap. A second drain shows all zeros.
- Packet {4,7} (no match) then packet {12,0} (out of range) → drop_count = 2, accumulators unchanged, spike_ready returns high after each.
- timestep_end pulsed during SEARCH of packet {4,1} → spike_ready stays low; drain starts right after ACCUM and includes value 100 for neuron 4.
- timestep_end and spike_valid in the same IDLE cycle → packet not accepted, drain runs, packet accepted in the first IDLE cycle after the drain.
- RESET asserted during drain beat 3 → acc_valid = 0 immediately, state IDLE, and a following drain reports all zeros; configuration preserved, so packet {4,2} still accumulates -30.
